// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with one history bit per entry.
// Lookup is combinational on PCF; EX corrections allocate/update at PCE.
module branch_target_buffer #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          PCF,
  output logic [1:0]           BranchFlagsF,
  output logic [31:0]          PredictedPCF,
  input  logic [31:0]          PCE,
  input  logic [31:0]          BranchTargetE,
  input  logic [1:0]           BranchE,
  input  logic                 BrValidE,
  input  logic                 StallE,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] state;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f;
  logic [INDEX_BITS-1:0] idx_e;
  logic [TAG_W-1:0]      tag_f;
  logic [TAG_W-1:0]      tag_e;
  logic                  hit;
  logic                  taken;
  logic                  upd;
  logic                  unused_lsbs;

  assign idx_f = PCF[INDEX_BITS+1:2];
  assign tag_f = PCF[31:INDEX_BITS+2];
  assign idx_e = PCE[INDEX_BITS+1:2];
  assign tag_e = PCE[31:INDEX_BITS+2];
  assign unused_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign hit   = valid[idx_f] && (tags[idx_f] == tag_f);
  assign taken = hit && state[idx_f];

  assign BranchFlagsF = {taken, hit};
  assign PredictedPCF = taken ? targets[idx_f] : PCF + 32'd4;

  // Every non-zero correction rewrites the whole entry
  assign upd = !rst && !StallE && (BranchE != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      state <= '0;
    end else if (upd) begin
      valid[idx_e] <= 1'b1;
      state[idx_e] <= (BranchE != 2'b11);
    end
  end

  always_ff @(posedge clk) begin
    if (upd) begin
      tags[idx_e]    <= tag_e;
      targets[idx_e] <= BranchTargetE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else if (!StallE) begin
      if (BrValidE && BranchCount != CMAX)
        BranchCount <= BranchCount + 1'b1;
      if (BranchE != 2'b00 && MispredCount != CMAX)
        MispredCount <= MispredCount + 1'b1;
    end
  end

  // A correction must come from a conditional branch
  a_corr_has_branch: assert property (
    @(posedge clk) disable iff (rst)
    !(BranchE != 2'b00 && !BrValidE));

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboarded random bench for branch_target_buffer.
// Reference model keys entries by word address per index.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = '0;
  logic [31:0] PCE = '0;
  logic [31:0] BranchTargetE = '0;
  logic [1:0]  BranchE = '0;
  logic        BrValidE = 1'b0;
  logic        StallE = 1'b0;
  logic [1:0]  BranchFlagsF, flags4;
  logic [31:0] PredictedPCF, ppc4;
  logic [31:0] BranchCount, MispredCount;
  logic [3:0]  bc4, mc4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.INDEX_BITS(6), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .BranchFlagsF(BranchFlagsF), .PredictedPCF(PredictedPCF),
    .PCE(PCE), .BranchTargetE(BranchTargetE), .BranchE(BranchE),
    .BrValidE(BrValidE), .StallE(StallE),
    .BranchCount(BranchCount), .MispredCount(MispredCount));

  branch_target_buffer #(.INDEX_BITS(6), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .PCF(PCF),
    .BranchFlagsF(flags4), .PredictedPCF(ppc4),
    .PCE(PCE), .BranchTargetE(BranchTargetE), .BranchE(BranchE),
    .BrValidE(BrValidE), .StallE(StallE),
    .BranchCount(bc4), .MispredCount(mc4));

  typedef struct {
    logic [1:0]  f;
    logic [31:0] p;
    logic [31:0] bc;
    logic [31:0] mc;
    logic [3:0]  bc4;
    logic [3:0]  mc4;
  } exp_t;

  exp_t q[$];

  // Model: per index, the word address that owns it, its target, its bit
  bit [29:0] m_word [int];
  bit [31:0] m_tgt  [int];
  bit        m_tk   [int];
  longint    m_bc;
  longint    m_mc;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic void model_clear();
    m_word.delete();
    m_tgt.delete();
    m_tk.delete();
    m_bc = 0;
    m_mc = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc,
                                       output bit hit, output bit tk,
                                       output logic [31:0] tgt);
    int i = idx_of(pc);
    hit = m_word.exists(i) && (m_word[i] == pc[31:2]);
    tk  = hit && m_tk[i];
    tgt = hit ? m_tgt[i] : 32'd0;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic [31:0] pcf, input logic [31:0] pce,
                      input logic [31:0] tgt, input logic [1:0] be,
                      input logic bv, input logic st, input logic r);
    exp_t e;
    bit hit, tk;
    logic [31:0] mt;
    int i;
    @(posedge clk);
    #1;
    rst = r; PCF = pcf; PCE = pce; BranchTargetE = tgt;
    BranchE = be; BrValidE = bv; StallE = st;
    if (r) model_clear();
    model_lookup(pcf, hit, tk, mt);
    e.f   = {tk, hit};
    e.p   = tk ? mt : pcf + 32'd4;
    e.bc  = m_bc[31:0];
    e.mc  = m_mc[31:0];
    e.bc4 = (m_bc > 15) ? 4'hF : m_bc[3:0];
    e.mc4 = (m_mc > 15) ? 4'hF : m_mc[3:0];
    q.push_back(e);
    if (!r && !st) begin
      if (be != 2'b00) begin
        i = idx_of(pce);
        m_word[i] = pce[31:2];
        m_tgt[i]  = tgt;
        m_tk[i]   = (be != 2'b11);
      end
      m_bc += bv;
      m_mc += (be != 2'b00);
    end
  endtask

  task automatic idle(input logic [31:0] pcf);
    step(pcf, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and check that it acts before the next edge
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("async_flags", {30'd0, BranchFlagsF}, 32'd0);
    chk("async_ppc", PredictedPCF, PCF + 32'd4);
    chk("async_bc", BranchCount, 32'd0);
    chk("async_mc", MispredCount, 32'd0);
    chk("async_bc4", {28'd0, bc4}, 32'd0);
    chk("async_mc4", {28'd0, mc4}, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("flags", {30'd0, BranchFlagsF}, {30'd0, e.f});
        chk("ppc", PredictedPCF, e.p);
        chk("bcnt", BranchCount, e.bc);
        chk("mcnt", MispredCount, e.mc);
        chk("bcnt4", {28'd0, bc4}, {28'd0, e.bc4});
        chk("mcnt4", {28'd0, mc4}, {28'd0, e.mc4});
      end
    end
  end

  initial begin : stim
    logic [31:0] pcf, pce, tgt;
    logic [1:0] be;
    logic bv, st, act;
    bit hit, tk;
    logic [31:0] mt;
    int waitc;
    model_clear();
    step(32'h40, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    // allocate, then train not-taken and back
    step(32'h40, 32'h40, 32'h100, 2'b01, 1'b1, 1'b0, 1'b0);
    idle(32'h40);
    step(32'h40, 32'h40, 32'h100, 2'b11, 1'b1, 1'b0, 1'b0);
    idle(32'h40);
    step(32'h40, 32'h40, 32'h100, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(32'h40);
    // alias at the same index evicts the old owner
    step(32'h40, 32'h140, 32'h200, 2'b01, 1'b1, 1'b0, 1'b0);
    idle(32'h40);
    idle(32'h140);
    // stalled corrections are dropped, then same-cycle bypass is old data
    repeat (3) step(32'h80, 32'h80, 32'h300, 2'b01, 1'b1, 1'b1, 1'b0);
    idle(32'h80);
    step(32'h80, 32'h80, 32'h300, 2'b01, 1'b1, 1'b0, 1'b0);
    idle(32'h80);
    idle(32'hFFFF_FFFC);
    step(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h8, 2'b01, 1'b1, 1'b0, 1'b0);
    idle(32'hFFFF_FFFC);
    async_reset();
    step(32'h80, 32'h40, 32'h100, 2'b01, 1'b1, 1'b0, 1'b1);
    idle(32'h80);
    idle(32'h40);
    for (int n = 0; n < 800; n++) begin
      pcf = {22'(($urandom % 4) * 32'h0040_1001), 8'(($urandom % 8) << 2), 2'b00};
      pce = {22'(($urandom % 4) * 32'h0040_1001), 8'(($urandom % 8) << 2), 2'b00};
      tgt = $urandom & 32'hFFFF_FFFC;
      st  = ($urandom % 5) == 0;
      bv  = ($urandom % 4) != 0;
      if (bv && ($urandom % 4) == 0) begin
        be = 2'($urandom % 4);
      end else if (bv) begin
        act = $urandom % 2;
        model_lookup(pce, hit, tk, mt);
        if (!hit)            be = act ? 2'b01 : 2'b00;
        else if (tk && !act) be = 2'b11;
        else if (!tk && act) be = 2'b10;
        else                 be = 2'b00;
      end else begin
        be = 2'b00;
      end
      if (n == 400) async_reset();
      step(pcf, pce, tgt, be, bv, st, (n == 400) ? 1'b1 : 1'b0);
    end
    idle(32'h0);
    waitc = 0;
    while (q.size() > 0 && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    #1;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
